// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : IF stage that owns the PC, fetches from a combinational-read
//            instruction memory and fills the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int           ADDRESSWIDTH        = 32,
  parameter int           INSTRUCTION_WIDTH   = 32,
  parameter int           BYTESPERINSTRUCTION = 4,
  parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0,
  parameter logic [5:0]   HALT_OPCODE         = 6'h11
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDRESSWIDTH-1:0]      imem_address,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [ADDRESSWIDTH-1:0]      redirect_target,
  output logic                         ifid_valid,
  output logic [INSTRUCTION_WIDTH-1:0] ifid_instruction,
  output logic [ADDRESSWIDTH-1:0]      ifid_pc,
  output logic [ADDRESSWIDTH-1:0]      ifid_pc_plus4,
  output logic                         halted,
  output logic                         misaligned_fault,
  output logic [31:0]                  fetch_count
);

  localparam int                    c_ALIGN_BITS = $clog2(BYTESPERINSTRUCTION);
  localparam logic [ADDRESSWIDTH-1:0] c_INC      = ADDRESSWIDTH'(BYTESPERINSTRUCTION);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t                         r_state,  w_state_next;
  logic [ADDRESSWIDTH-1:0]        r_pc,     w_pc_next;
  logic                           r_valid,  w_valid_next;
  logic [INSTRUCTION_WIDTH-1:0]   r_instr,  w_instr_next;
  logic [ADDRESSWIDTH-1:0]        r_ipc,    w_ipc_next;
  logic [ADDRESSWIDTH-1:0]        r_ipc4,   w_ipc4_next;
  logic [31:0]                    r_count,  w_count_next;

  logic [ADDRESSWIDTH-1:0]        w_pc_inc;
  logic                           w_target_aligned;
  logic                           w_is_halt;

  assign w_pc_inc         = r_pc + c_INC;
  assign w_target_aligned = (redirect_target[c_ALIGN_BITS-1:0] == '0);
  assign w_is_halt        = (imem_instruction[INSTRUCTION_WIDTH-1 -: 6] == HALT_OPCODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
      r_ipc4  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      r_instr <= w_instr_next;
      r_ipc   <= w_ipc_next;
      r_ipc4  <= w_ipc4_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_instr_next = r_instr;
    w_ipc_next   = r_ipc;
    w_ipc4_next  = r_ipc4;
    w_count_next = r_count;

    unique case (r_state)
      S_FETCH: begin
        if (redirect_valid) begin
          w_pc_next    = redirect_target;
          w_valid_next = 1'b0;
          w_instr_next = '0;
          if (!w_target_aligned) w_state_next = S_FAULT;
        end else if (!stall) begin
          w_valid_next = 1'b1;
          w_instr_next = imem_instruction;
          w_ipc_next   = r_pc;
          w_ipc4_next  = w_pc_inc;
          w_count_next = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
          // A HALT is delivered downstream but the PC parks on it.
          if (w_is_halt) w_state_next = S_HALTED;
          else           w_pc_next    = w_pc_inc;
        end
      end
      S_HALTED: begin
        if (redirect_valid) begin
          w_pc_next    = redirect_target;
          w_valid_next = 1'b0;
          w_instr_next = '0;
          w_state_next = w_target_aligned ? S_FETCH : S_FAULT;
        end else if (!stall) begin
          w_valid_next = 1'b0;
          w_instr_next = '0;
        end
      end
      S_FAULT: begin
        w_valid_next = 1'b0;
        w_instr_next = '0;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  assign imem_address     = r_pc;
  assign ifid_valid       = r_valid;
  assign ifid_instruction = r_instr;
  assign ifid_pc          = r_ipc;
  assign ifid_pc_plus4    = r_ipc4;
  assign halted           = (r_state == S_HALTED);
  assign misaligned_fault = (r_state == S_FAULT);
  assign fetch_count      = r_count;

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF-stage initiator for the byte-addressed, combinational-read instruction memory.
- Owns the program counter and drives the memory address; the memory returns one 32-bit instruction in the same cycle.
- Captures each instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, HALT detection and misaligned-target faults for the 5-stage MIPS-lite pipeline.

Parameters:
- ADDRESSWIDTH, 32, byte-address width of the PC and memory address.
- INSTRUCTION_WIDTH, 32, instruction word width.
- BYTESPERINSTRUCTION, 4, PC increment; alignment granule.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 6'h11, opcode field [31:26] that marks HALT.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_address  output  ADDRESSWIDTH  byte address to instruction memory; equals the PC register.
- imem_instruction  input  INSTRUCTION_WIDTH  instruction returned combinationally for imem_address.
- stall  input  1  hazard unit hold request.
- redirect_valid  input  1  taken branch/jump from a later stage.
- redirect_target  input  ADDRESSWIDTH  new PC when redirect_valid is high.
- ifid_valid  output  1  IF/ID register holds a real instruction.
- ifid_instruction  output  INSTRUCTION_WIDTH  IF/ID instruction; 0 (NOP) when the slot is a bubble.
- ifid_pc  output  ADDRESSWIDTH  PC of ifid_instruction.
- ifid_pc_plus4  output  ADDRESSWIDTH  ifid_pc + BYTESPERINSTRUCTION, modulo 2^ADDRESSWIDTH.
- halted  output  1  high while the FSM is in HALTED.
- misaligned_fault  output  1  high while the FSM is in FAULT; sticky until reset.
- fetch_count  output  32  number of instructions captured with valid; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC.
  - ifid_valid = 0, ifid_instruction = 0, ifid_pc = 0, ifid_pc_plus4 = 0.
  - halted = 0, misaligned_fault = 0, fetch_count = 0, state = FETCH.
  - Reset mid-operation discards all in-flight state; the first fetch is from RESET_PC in the first edge after deassertion.
- imem_address is driven directly from the PC register. Fetch latency is 1 cycle, from PC to IF/ID.
- FSM states: FETCH, HALTED, FAULT.
- FETCH, per edge, in priority order:
  1. redirect_valid = 1, target aligned (target[log2(BYTESPERINSTRUCTION)-1:0] == 0):
     - PC <= target; IF/ID <= bubble (valid 0, instruction 0).
     - Wins over stall.
     - fetch_count unchanged.
  2. redirect_valid = 1, target misaligned:
     - PC <= target; IF/ID <= bubble; state <= FAULT.
  3. stall = 1: PC and all IF/ID outputs hold.
  4. Otherwise:
     - ifid_instruction <= imem_instruction; ifid_pc <= PC; ifid_pc_plus4 <= PC + 4; ifid_valid <= 1.
     - fetch_count += 1, saturating.
     - If imem_instruction[31:26] == HALT_OPCODE: PC holds and state <= HALTED. The HALT itself is delivered valid.
     - Else PC <= PC + BYTESPERINSTRUCTION, wrapping at 2^ADDRESSWIDTH.
- HALTED:
  - PC holds; no further fetches.
  - On the first non-stalled edge, IF/ID <= bubble; it stays a bubble after that. Under stall, IF/ID holds.
  - redirect_valid = 1 means the HALT was wrong-path. Apply the same aligned/misaligned rules as FETCH, with aligned going to state FETCH; halted drops next cycle.
- FAULT:
  - PC and fetch_count hold; IF/ID <= bubble each edge.
  - Ignores stall and redirect; exit only by reset.
- An aligned PC always fetches, even if memory returns 32'hDEADBEEF; the memory sentinel is not treated as a fault here.
- Simultaneous events:
  - redirect + stall: redirect wins.
  - HALT fetched while stall = 1: not captured, not detected until stall drops.

Test Plan:
- Reset release with memory {0x20010005, 0x20020003, 0x00221820} at 0/4/8 -> imem_address 0, 4, 8, C on successive cycles; IF/ID (0x20010005, pc 0, pc+4 4), then (0x20020003, pc 4); fetch_count 3 after 3 edges.
- stall = 1 for 2 cycles at PC = 8 -> imem_address stays 8; ifid_pc stays 4; fetch_count unchanged; resumes at 8 when stall drops.
- redirect_valid = 1, target 0x40, with stall = 1 at PC = C -> next cycle PC = 0x40, ifid_valid = 0, ifid_instruction = 0; following edge captures mem[0x40] with ifid_pc 0x40.
- Fetch 0x44000000 (opcode 0x11) at PC 0x10 -> ifid_valid 1 with that instruction; halted = 1; PC stays 0x10; next edge gives a bubble. Then redirect to 0x20 -> halted 0, fetch resumes at 0x20.
- redirect_target 0x22 -> misaligned_fault = 1 next cycle, imem_address 0x22, ifid_valid 0. Later redirect to 0x30 is ignored; reset clears fault and PC = RESET_PC.
- Assert reset mid-stream at PC = 0x1C, ifid_valid 1 -> outputs clear immediately without waiting for a clock edge; fetch_count 0; first post-reset capture is mem[RESET_PC].
